// File: rtl/tx_gearbox_seq.sv
// TX gearbox sequencer: brings the link up after transceiver ready plus a holdoff,
// then drives the 33-cycle gearbox sequence, encoder pause, word select and header-valid strobes.
module tx_gearbox_seq #(
  parameter int unsigned INIT_HOLDOFF = 64,
  parameter int unsigned PAUSE_INDEX  = 32
) (
  input  logic       i_txc,
  input  logic       i_reset_n,
  input  logic       i_gt_ready,
  output logic [5:0] o_gearbox_seq,
  output logic       o_tx_pause,
  output logic       o_frame_word,
  output logic       o_header_valid,
  output logic       o_init_done,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_READY = 2'd1,
    HOLDOFF    = 2'd2,
    RUN        = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(INIT_HOLDOFF - 1);
  localparam logic [5:0]  SEQ_LAST  = 6'd32;
  localparam logic [5:0]  PAUSE_SEQ = 6'(PAUSE_INDEX);

  state_t      state, state_nxt;
  logic [15:0] hold_cnt, hold_cnt_nxt;
  logic [5:0]  seq_nxt;
  logic        active_nxt, continuing;
  logic        pause_nxt, frame_nxt, header_nxt, done_nxt;

  // State register; every output is registered alongside it.
  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      o_gearbox_seq  <= '0;
      o_tx_pause     <= 1'b0;
      o_frame_word   <= 1'b0;
      o_header_valid <= 1'b0;
      o_init_done    <= 1'b0;
    end else begin
      state          <= state_nxt;
      hold_cnt       <= hold_cnt_nxt;
      o_gearbox_seq  <= seq_nxt;
      o_tx_pause     <= pause_nxt;
      o_frame_word   <= frame_nxt;
      o_header_valid <= header_nxt;
      o_init_done    <= done_nxt;
    end
  end

  assign o_state = state;

  // Next-state logic; loss of ready wins over every other transition.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       state_nxt = WAIT_READY;
      WAIT_READY: if (i_gt_ready) state_nxt = HOLDOFF;
      HOLDOFF: begin
        if (!i_gt_ready)                state_nxt = WAIT_READY;
        else if (hold_cnt == HOLD_LAST) state_nxt = RUN;
      end
      RUN:        if (!i_gt_ready) state_nxt = WAIT_READY;
      default:    state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    active_nxt = (state_nxt == HOLDOFF) || (state_nxt == RUN);
    continuing = active_nxt && ((state == HOLDOFF) || (state == RUN));

    if (!continuing || (o_gearbox_seq == SEQ_LAST)) seq_nxt = '0;
    else                                            seq_nxt = o_gearbox_seq + 6'd1;

    pause_nxt = active_nxt && (seq_nxt == PAUSE_SEQ);

    // Word select restarts at 0 each period so 33 cycles carry exactly 16 blocks.
    if (!active_nxt || (seq_nxt == '0)) frame_nxt = 1'b0;
    else if (pause_nxt)                 frame_nxt = o_frame_word;
    else                                frame_nxt = ~o_frame_word;

    header_nxt = active_nxt && !frame_nxt && !pause_nxt;
    done_nxt   = (state_nxt == RUN);

    if ((state_nxt == HOLDOFF) && (state != HOLDOFF))  hold_cnt_nxt = '0;
    else if ((state == HOLDOFF) && (hold_cnt != '1))   hold_cnt_nxt = hold_cnt + 16'd1;
    else                                               hold_cnt_nxt = hold_cnt;
  end

endmodule

// File: doc/tx_gearbox_seq.md
TX_GEARBOX_SEQ -- requirements
Module: tx_gearbox_seq

Interface
REQ-001 The block SHALL have parameter INIT_HOLDOFF, default 64, giving the number of cycles between transceiver ready and init done (legal range 1..65535).
REQ-002 The block SHALL have parameter PAUSE_INDEX, default 32, giving the sequence value on which the encoder is paused (legal range 0..32).
REQ-003 The block SHALL have port i_txc, input, 1 bit: TX clock; the only clock in the block.
REQ-004 The block SHALL have port i_reset_n, input, 1 bit: asynchronous active-low reset; assertion is asynchronous, release is sampled on i_txc.
REQ-005 The block SHALL have port i_gt_ready, input, 1 bit: transceiver TX path ready, synchronous to i_txc.
REQ-006 The block SHALL have port o_gearbox_seq, output, 6 bits: transceiver gearbox sequence value, range 0..32.
REQ-007 The block SHALL have port o_tx_pause, output, 1 bit: encoder/scrambler pause.
REQ-008 The block SHALL have port o_frame_word, output, 1 bit: 0 = lower 32-bit word of the 66-bit block, 1 = upper word.
REQ-009 The block SHALL have port o_header_valid, output, 1 bit: the sync header on the encoder output is valid this cycle.
REQ-010 The block SHALL have port o_init_done, output, 1 bit: link TX is initialised; the encoder sends normal data.
REQ-011 The block SHALL have port o_state, output, 2 bits: FSM state for debug (0 = IDLE, 1 = WAIT_READY, 2 = HOLDOFF, 3 = RUN).

Function
REQ-012 The FSM states SHALL be IDLE, WAIT_READY, HOLDOFF and RUN; all outputs SHALL be registered.
REQ-013 Transitions SHALL be:
- IDLE->WAIT_READY unconditionally, on the first clock after reset release.
- WAIT_READY->HOLDOFF when i_gt_ready=1.
- HOLDOFF->RUN when the holdoff counter reaches INIT_HOLDOFF-1 with i_gt_ready=1.
- HOLDOFF or RUN ->WAIT_READY whenever i_gt_ready=0; this takes priority over every other transition.
REQ-014 The 16-bit holdoff counter SHALL clear on entry to HOLDOFF, increment once per cycle in HOLDOFF, and never wrap.
REQ-015 o_init_done SHALL be 1 exactly when the state is RUN; it SHALL deassert on the cycle after i_gt_ready falls.
REQ-016 In IDLE and WAIT_READY, the sequence counter SHALL hold at 0 and o_frame_word SHALL hold at 0.
REQ-017 In HOLDOFF and RUN, the sequence counter SHALL count 0,1,...,32,0 with wrap at 32, so the period is 33 cycles.
REQ-018 o_gearbox_seq SHALL equal the sequence counter.
REQ-019 o_tx_pause SHALL be 1 exactly when o_gearbox_seq==PAUSE_INDEX and the state is HOLDOFF or RUN.
REQ-020 o_frame_word SHALL toggle on every non-pause cycle in HOLDOFF and RUN, and hold its value during a pause cycle.
REQ-021 o_frame_word SHALL be forced to 0 on the cycle o_gearbox_seq returns to 0, so that each 33-cycle period carries exactly 16 blocks (32 words).
REQ-022 o_header_valid SHALL equal (o_frame_word==0) AND (o_tx_pause==0) AND (state is HOLDOFF or RUN).
REQ-023 When i_gt_ready drops, on the next cycle the sequence counter, o_frame_word and o_tx_pause SHALL be 0, and the next entry to HOLDOFF SHALL restart from sequence 0.
REQ-024 Re-assertion of i_gt_ready on the same cycle as the drop is taken SHALL be ignored; the FSM enters WAIT_READY first.

Reset
REQ-025 While i_reset_n=0, the block SHALL hold: state=IDLE, sequence=0, holdoff counter=0, o_gearbox_seq=0, o_tx_pause=0, o_frame_word=0, o_header_valid=0, o_init_done=0, o_state=0.
REQ-026 Reset asserted mid-operation, including on a pause cycle, SHALL take effect immediately without waiting for a clock edge.
REQ-027 After reset release, the earliest possible o_init_done SHALL be INIT_HOLDOFF+2 cycles after i_gt_ready is high.

Verification
REQ-028 With INIT_HOLDOFF=4, release reset with i_gt_ready=1 -> o_state steps 0,1,2,2,2,2,3 and o_init_done rises on the 7th cycle.
REQ-029 In RUN with PAUSE_INDEX=32, observe 99 cycles -> o_tx_pause is high only at seq 32 (3 pulses), 48 o_header_valid pulses, and o_frame_word=0 at every seq 0.
REQ-030 With PAUSE_INDEX=5, observe one period -> pause at seq 5, o_frame_word holds over seq 5, and 16 header-valid pulses occur per period.
REQ-031 Drop i_gt_ready for 1 cycle at seq 17 in RUN -> next cycle shows o_init_done=0, seq=0, o_frame_word=0, state=WAIT_READY; the restart repeats the full holdoff.
REQ-032 Assert i_reset_n=0 asynchronously mid-cycle at seq 32 -> all outputs are 0 before the next i_txc edge; after release, the sequence restarts from 0.
